// File: rtl/ps2_stim_gen_pkg.sv
// ps2_defs: shared PS/2 definitions, used by the frame generator and the
// keyboard receiver.
//   FRAME_BITS      : bits per device-to-host frame (start, 8 data, parity, stop)
//   ps2_state_e     : generator FSM encoding
//   ps2_odd_parity  : parity bit that makes data + parity hold an odd number of ones
package ps2_defs;

  localparam int FRAME_BITS = 11;
  localparam int LAST_BIT   = FRAME_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ps2_state_e;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, reset_in : clock, synchronous active-high reset (flushes contents)
//   push_i        : write request, ignored while full (even if popping)
//   wr_data_i     : data to write
//   pop_i         : read request, ignored while empty
//   rd_data_o     : head entry, valid whenever !empty_o
//   full_o, empty_o, count_o : occupancy, all from the registered count
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign push = push_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ps2_stim_gen.sv
// ps2_stim_gen: PS/2 device-side frame generator.
// Queued bytes are serialised as 11-bit device-to-host frames.
//   clk, reset_in      : clock, synchronous active-high reset
//   in_data/inject_err : byte to send; inject_err inverts that frame's parity
//   in_valid/in_ready  : write handshake
//   ps2c, ps2d         : PS/2 clock and data, both idle high
//   busy               : frame or gap in progress, or queue non-empty
//   frames_sent        : completed frame count (wraps)
//   state_dbg          : current FSM state
// Handshake: a byte is written on a rising edge where in_valid && in_ready;
// in_ready is !full from the registered count, so a pop in the same cycle
// never makes room for a write to a full queue.
module ps2_stim_gen
  import ps2_defs::*;
#(
  parameter int CLK_HALF = 2500,
  parameter int GAP      = 5000,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [7:0]  in_data,
  input  logic        inject_err,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ps2c,
  output logic        ps2d,
  output logic        busy,
  output logic [15:0] frames_sent,
  output ps2_state_e  state_dbg
);

  // One counter serves both the half-period phase and the inter-frame gap.
  localparam int CNT_MAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

  ps2_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_hi_q, phase_hi_d;
  logic [3:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;  // bit 0 is the level on ps2d
  logic                  ps2c_q, ps2c_d;
  logic [15:0]           frames_q, frames_d;

  logic                  fifo_full, fifo_empty, pop;
  logic [8:0]            fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_in  (reset_in),
    .push_i    (in_valid),
    .wr_data_i ({inject_err, in_data}),
    .pop_i     (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_hi_q <= 1'b1;
      idx_q      <= '0;
      shreg_q    <= '1;
      ps2c_q     <= 1'b1;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_hi_q <= phase_hi_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      ps2c_q     <= ps2c_d;
      frames_q   <= frames_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_hi_d = phase_hi_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    ps2c_d     = ps2c_q;
    frames_d   = frames_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ps2c_d  = 1'b1;
        shreg_d = '1;
        cnt_d   = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          // {stop, parity, data, start}; start bit lands on ps2d immediately
          shreg_d    = {1'b1, ps2_odd_parity(fifo_head[7:0]) ^ fifo_head[8],
                        fifo_head[7:0], 1'b0};
          idx_d      = '0;
          phase_hi_d = 1'b1;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (phase_hi_q) begin
            phase_hi_d = 1'b0;
            ps2c_d     = 1'b0;
          end else begin
            phase_hi_d = 1'b1;
            ps2c_d     = 1'b1;
            if (idx_q < 4'(LAST_BIT)) begin
              // next bit appears together with the rising ps2c
              idx_d   = idx_q + 4'd1;
              shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
            end else begin
              shreg_d  = '1;
              frames_d = frames_q + 16'd1;
              state_d  = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shreg_d = '1;
        ps2c_d  = 1'b1;
      end
    endcase
  end

  assign in_ready    = !fifo_full;
  assign ps2c        = ps2c_q;
  assign ps2d        = shreg_q[0];
  assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
  assign frames_sent = frames_q;
  assign state_dbg   = state_q;

endmodule
